// File: rtl/gnrl_lat_fifo.sv
// gnrl_lat_fifo: credit-metered return buffer sitting behind a fixed-latency DFF pipe.
// Latency: push to out_vld is 1 cycle; with GNRL_LAT_FIFO_BYPASS_EN an empty FIFO forwards ret_data in the same cycle.
// Backpressure: out_rdy low holds entries; issue_rdy drops once all DEPTH credits are outstanding, so returns always fit.
module gnrl_lat_fifo #(
  parameter int DWIDTH = 32,
  parameter int LAT    = 4,
  parameter int DEPTH  = 8,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_vld,
  output logic              issue_rdy,
  input  logic              ret_vld,
  input  logic [DWIDTH-1:0] ret_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DWIDTH-1:0] out_data,
  output logic [CW-1:0]     level,
  output logic [CW-1:0]     credits,
  output logic              ovf_err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Below DEPTH = LAT+1 the credit loop caps issue rate; the logic is the same,
  // this scope only marks such builds in the hierarchy.
  if (DEPTH < LAT + 1) begin : g_rate_limited
  end

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     level_q, level_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              ovf_q, ovf_d;

  logic full, empty, issue, pop, fifo_pop, push, wr_en, byp;

  assign full      = (level_q == DEPTH_C);
  assign empty     = (level_q == '0);
  assign issue_rdy = (credits_q != '0);
  assign issue     = issue_vld & issue_rdy;

`ifdef GNRL_LAT_FIFO_BYPASS_EN
  // An empty FIFO presents the returning result directly on the output port.
  assign byp = empty & ret_vld;

  // Head of storage when occupied, otherwise the bypassed return, otherwise zero.
  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = mem_q[rptr_q];
    end else if (byp) begin
      out_data = ret_data;
    end
  end
`else
  assign byp = 1'b0;

  // Head of storage when occupied, otherwise zero; no path from ret_* to out_*.
  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = mem_q[rptr_q];
    end
  end
`endif

  assign out_vld  = ~empty | byp;
  assign pop      = out_vld & out_rdy;
  // Only pops of stored entries move the read side; a bypassed pop never touched storage.
  assign fifo_pop = pop & ~empty;
  // A bypassed result taken by the consumer this cycle is not stored.
  assign push     = ret_vld & ~(byp & out_rdy);
  // When full, a push lands only if the head leaves in the same cycle.
  assign wr_en    = push & (~full | fifo_pop);

  // Next-state for pointers, occupancy, credits and the sticky overflow flag.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    credits_d = credits_q;
    ovf_d     = ovf_q;
    if (wr_en) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (fifo_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({wr_en, fifo_pop})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
    // Credit leaves on issue and comes back when the consumer takes the entry.
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    if (push && full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      credits_q <= DEPTH_C;
      ovf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      credits_q <= credits_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is data-only and left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= ret_data;
    end
  end

  assign level   = level_q;
  assign credits = credits_q;
  assign ovf_err = ovf_q;

endmodule

// File: tb/tb_gnrl_lat_fifo.sv
// tb_gnrl_lat_fifo: table vectors plus scoreboarded sequences for gnrl_lat_fifo.
// A behavioural LAT-stage pipe returns issued ids; expected results queue at issue.
// Summary line counts passed against total comparisons.
module tb_gnrl_lat_fifo;
  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef GNRL_LAT_FIFO_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_vld = 1'b0;
  logic          issue_rdy;
  logic          ret_vld = 1'b0;
  logic [DW-1:0] ret_data = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] level;
  logic [CW-1:0] credits;
  logic          ovf_err;

  always #5 clk = ~clk;

  gnrl_lat_fifo #(.DWIDTH(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_rdy(issue_rdy),
    .ret_vld(ret_vld), .ret_data(ret_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .level(level), .credits(credits), .ovf_err(ovf_err)
  );

  typedef struct {
    logic          iv;
    logic          rv;
    logic [DW-1:0] rd;
    logic          ordy;
    logic          e_irdy;
    logic          e_ovld;
    logic [DW-1:0] e_odat;
    logic [CW-1:0] e_lvl;
    logic [CW-1:0] e_cred;
  } vec_t;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] exp_q[$];
  logic          pipe_v[LAT];
  logic [DW-1:0] pipe_d[LAT];
  int            next_id = 0;
  int            n_out = 0;
  int            rdy_drops = 0;
  logic          force_v = 1'b0;
  logic [DW-1:0] force_d = '0;
  vec_t          tbl[7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic iv, input logic rv, input logic [DW-1:0] rd,
                              input logic ordy, input logic ei, input logic eo,
                              input logic [DW-1:0] ed, input int el, input int ec);
    vec_t v;
    v.iv = iv; v.rv = rv; v.rd = rd; v.ordy = ordy;
    v.e_irdy = ei; v.e_ovld = eo; v.e_odat = ed;
    v.e_lvl = CW'(el); v.e_cred = CW'(ec);
    return v;
  endfunction

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    issue_vld = 1'b0; ret_vld = 1'b0; ret_data = '0; out_rdy = 1'b0; force_v = 1'b0;
    rst = 1'b1;
    clear_pipe();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One clock of the pipe model: drive, check any pop against the scoreboard, advance.
  task automatic cyc(input logic iv, input logic ordy);
    logic acc;
    issue_vld = iv;
    out_rdy   = ordy;
    ret_vld   = force_v ? 1'b1 : pipe_v[LAT-1];
    ret_data  = force_v ? force_d : (pipe_v[LAT-1] ? pipe_d[LAT-1] : '0);
    #1;
    acc = issue_vld & issue_rdy;
    if (iv && !issue_rdy) rdy_drops++;
    if (out_vld && out_rdy) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got output %0h, expected none", out_data);
      end else begin
        chk("sb_order", out_data, exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(DW'(next_id));
    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = acc;
    pipe_d[0] = DW'(next_id);
    if (acc) next_id++;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 0, 8);
    tbl[1] = mk(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 0, 7);
    tbl[2] = mk(1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, BYP,  BYP ? 32'hA1 : 32'h0, 0, 6);
    tbl[3] = mk(1'b0, 1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 32'hA1, 1, 6);
    tbl[4] = mk(1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA1, 2, 6);
    tbl[5] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB2, 1, 6);
    tbl[6] = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 0, 7);

    #2;
    do_reset();
    chk("rst_issue_rdy", issue_rdy, 1);
    chk("rst_credits", credits, 8);
    chk("rst_level", level, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf_err, 0);

    // Table vectors: outputs checked before the edge that applies each row.
    for (int i = 0; i < 7; i++) begin
      issue_vld = tbl[i].iv; ret_vld = tbl[i].rv; ret_data = tbl[i].rd; out_rdy = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_issue_rdy", i), issue_rdy, tbl[i].e_irdy);
      chk($sformatf("tbl%0d_out_vld", i), out_vld, tbl[i].e_ovld);
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_odat);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_credits", i), credits, tbl[i].e_cred);
      @(posedge clk); #1;
    end

    // Streaming at full rate.
    do_reset();
    next_id = 0; n_out = 0; rdy_drops = 0;
    repeat (100) cyc(1'b1, 1'b1);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cyc(1'b0, 1'b1);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_count", n_out, 100);
    chk("stream_rdy_drops", rdy_drops, 0);
    chk("stream_ovf", ovf_err, 0);
    chk("stream_credits", credits, 8);
    chk("stream_level", level, 0);

    // Back-pressure: credits limit issue to DEPTH, then drain resumes issue.
    do_reset();
    next_id = 0;
    repeat (12 + LAT + 1) cyc(1'b1, 1'b0);
    chk("bp_accepted", next_id, 8);
    chk("bp_issue_rdy_low", issue_rdy, 0);
    chk("bp_level", level, 8);
    chk("bp_credits", credits, 0);
    cyc(1'b1, 1'b1);
    chk("bp_issue_resume", issue_rdy, 1);
    repeat (3) cyc(1'b1, 1'b1);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cyc(1'b0, 1'b1);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_level_end", level, 0);
    chk("bp_credits_end", credits, 8);

    // Simultaneous issue/pop, full push/pop across the wrap, then overflow.
    do_reset();
    next_id = 0;
    repeat (5) cyc(1'b1, 1'b0);
    repeat (LAT + 1) cyc(1'b0, 1'b0);
    chk("sim_credits_pre", credits, 3);
    chk("sim_level_pre", level, 5);
    cyc(1'b1, 1'b1);
    chk("sim_credits_same", credits, 3);
    chk("sim_level_pop", level, 4);
    repeat (3) cyc(1'b1, 1'b0);
    repeat (LAT + 1) cyc(1'b0, 1'b0);
    chk("full_level", level, 8);
    chk("full_credits", credits, 0);
    force_v = 1'b1; force_d = 32'hA5A5_0001;
    exp_q.push_back(force_d);
    cyc(1'b0, 1'b1);
    force_v = 1'b0;
    chk("full_pushpop_level", level, 8);
    chk("full_pushpop_credits", credits, 1);
    force_v = 1'b1; force_d = 32'h0000_DEAD;
    cyc(1'b0, 1'b0);
    force_v = 1'b0;
    chk("ovf_set", ovf_err, 1);
    chk("ovf_level", level, 8);
    cyc(1'b0, 1'b0);
    chk("ovf_sticky", ovf_err, 1);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc(1'b0, 1'b1);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_level_end", level, 0);
    chk("ovf_sticky_end", ovf_err, 1);

    // Reset asserted mid-cycle with work in flight.
    repeat (3) cyc(1'b1, 1'b0);
    issue_vld = 1'b0; ret_vld = 1'b0; ret_data = '0;
    #3 rst = 1'b1;
    #1;
    chk("mrst_issue_rdy", issue_rdy, 1);
    chk("mrst_credits", credits, 8);
    chk("mrst_level", level, 0);
    chk("mrst_out_vld", out_vld, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_ovf", ovf_err, 0);
    do_reset();

    // Return into an empty FIFO: same-cycle forward with bypass, one cycle later without.
    issue_vld = 1'b1;
    @(posedge clk); #1;
    issue_vld = 1'b0;
    chk("lat_credits_issue", credits, 7);
    ret_vld = 1'b1; ret_data = 32'h0000_1234; out_rdy = 1'b1;
    #1;
`ifdef GNRL_LAT_FIFO_BYPASS_EN
    chk("byp_out_vld", out_vld, 1);
    chk("byp_out_data", out_data, 32'h1234);
    @(posedge clk); #1;
    ret_vld = 1'b0; ret_data = '0;
    #1;
    chk("byp_level", level, 0);
    chk("byp_credits", credits, 8);
    chk("byp_out_vld_after", out_vld, 0);
`else
    chk("nobyp_out_vld", out_vld, 0);
    chk("nobyp_out_data", out_data, 0);
    @(posedge clk); #1;
    ret_vld = 1'b0; ret_data = '0;
    #1;
    chk("nobyp_level", level, 1);
    chk("nobyp_out_vld_next", out_vld, 1);
    chk("nobyp_out_data_next", out_data, 32'h1234);
    chk("nobyp_credits_hold", credits, 7);
    @(posedge clk); #1;
    chk("nobyp_level_after", level, 0);
    chk("nobyp_credits_after", credits, 8);
`endif
    out_rdy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
